// File: rtl/measure_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | measure_pkg: XGMII characters, frame layout and state types shared  |
// | by the measurement blocks.            Revision: 1.0                 |
// +--------------------------------------------------------------------+
package measure_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  localparam logic [39:0] MAGIC_CODE_DEFAULT = 40'h4D_45_41_53_52;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP  = 8'h11;

  // Word indices counted from the start word (index 0)
  localparam logic [7:0] WORD_ETYPE    = 8'd2;
  localparam logic [7:0] WORD_PROTO    = 8'd3;
  localparam logic [7:0] WORD_IP_HI    = 8'd4;
  localparam logic [7:0] WORD_IP_LO    = 8'd5;
  localparam logic [7:0] WORD_MAGIC    = 8'd6;
  localparam logic [7:0] WORD_TS_LO    = 8'd7;
  localparam logic [7:0] WORD_MIN_TERM = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  // Bytes from DA through FCS for a terminate in lane `lane` of word `word_idx`
  function automatic logic [15:0] frame_bytes(input logic [7:0] word_idx,
                                              input logic [2:0] lane);
    logic [18:0] full;
    full = (19'(word_idx) - 19'd1) * 19'd8 + 19'(lane);
    return (full > 19'h0FFFF) ? 16'hFFFF : full[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/measure_sec_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | measure_sec_tick: one-cycle tick every SEC_COUNT cycles.            |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module measure_sec_tick #(
  parameter int unsigned SEC_COUNT = 156250000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  generate
    if (SEC_COUNT <= 1) begin : g_unit
      assign tick = 1'b1;
    end else begin : g_count
      localparam int unsigned CW = $clog2(SEC_COUNT);
      localparam logic [CW-1:0] RELOAD = CW'(SEC_COUNT - 1);
      logic [CW-1:0] count;

      // Count starts at 0 so the first pass is one cycle longer than the reload
      // span, placing the first tick exactly SEC_COUNT cycles after release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (count == '0) begin
          count <= RELOAD;
        end else begin
          count <= count - 1'b1;
        end
      end

      assign tick = (count == CW'(1));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rx_measure.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_measure: XGMII RX parser for timestamped test frames, one-way    |
// | latency and per-interval rates.        Revision: 1.0                |
// +--------------------------------------------------------------------+
module rx_measure
  import measure_pkg::*;
#(
  parameter logic [39:0] MAGIC_CODE = MAGIC_CODE_DEFAULT,
  parameter int unsigned SEC_COUNT  = 156250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip
);

  // Magic bytes as they appear on lanes 2..6 (lane 2 in the low byte)
  localparam logic [39:0] MAGIC_LANES = {MAGIC_CODE[7:0], MAGIC_CODE[15:8],
                                         MAGIC_CODE[23:16], MAGIC_CODE[31:24],
                                         MAGIC_CODE[39:32]};

  rx_state_t   state;
  logic [7:0]  word_idx;
  logic [31:0] dst_ip;
  logic [31:0] tx_ts;
  logic [31:0] pps_acc;
  logic [31:0] byte_acc;

  logic        is_start;
  logic        term_found;
  logic [2:0]  term_lane;
  logic        err_found;
  logic        check_fail;
  logic        accept;
  logic        tick;
  logic [31:0] latency;
  logic [15:0] term_bytes;
  logic [31:0] pps_next;
  logic [32:0] byte_sum;
  logic [31:0] byte_next;

  assign is_start = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);

  always_comb begin
    term_found = 1'b0;
    term_lane  = 3'd0;
    err_found  = 1'b0;
    for (int l = 7; l >= 0; l--) begin
      if (xgmii_rxc[l] && (xgmii_rxd[8*l +: 8] == XGMII_TERM)) begin
        term_found = 1'b1;
        term_lane  = 3'(l);
      end
    end
    for (int l = 0; l < 8; l++) begin
      if (xgmii_rxc[l] && (xgmii_rxd[8*l +: 8] == XGMII_ERROR)) begin
        err_found = 1'b1;
      end
    end
  end

  always_comb begin
    check_fail = 1'b0;
    case (word_idx)
      WORD_ETYPE: check_fail = ({xgmii_rxd[39:32], xgmii_rxd[47:40]} != ETYPE_IPV4);
      WORD_PROTO: check_fail = (xgmii_rxd[63:56] != PROTO_UDP);
      WORD_MAGIC: check_fail = (xgmii_rxd[55:16] != MAGIC_LANES);
      default:    check_fail = 1'b0;
    endcase
  end

  // All checks sit below the minimum terminate word, so surviving in RECV
  // up to a terminate means every check has already passed.
  assign accept = (state == ST_RECV) && !is_start && term_found && !err_found &&
                  (word_idx >= WORD_MIN_TERM);

  assign latency    = global_counter - tx_ts;
  assign term_bytes = frame_bytes(word_idx, term_lane);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      word_idx   <= 8'd0;
      dst_ip     <= 32'd0;
      tx_ts      <= 32'd0;
      rx_latency <= 24'd0;
      rx_ipv4_ip <= 32'd0;
    end else if (is_start) begin
      state    <= ST_RECV;
      word_idx <= 8'd1;
    end else begin
      case (state)
        ST_RECV: begin
          if (word_idx != 8'hFF) begin
            word_idx <= word_idx + 8'd1;
          end
          if (term_found) begin
            state <= ST_IDLE;
            if (accept) begin
              rx_ipv4_ip <= dst_ip;
              rx_latency <= (latency[31:24] == 8'd0) ? latency[23:0] : 24'hFFFFFF;
            end
          end else if (err_found || check_fail) begin
            state <= ST_DROP;
          end else begin
            case (word_idx)
              WORD_IP_HI: dst_ip[31:16] <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
              WORD_IP_LO: dst_ip[15:0]  <= {xgmii_rxd[7:0], xgmii_rxd[15:8]};
              WORD_MAGIC: tx_ts[31:24]  <= xgmii_rxd[63:56];
              WORD_TS_LO: tx_ts[23:0]   <= {xgmii_rxd[7:0], xgmii_rxd[15:8], xgmii_rxd[23:16]};
              default: ;
            endcase
          end
        end
        ST_DROP: begin
          if (term_found) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  measure_sec_tick #(.SEC_COUNT(SEC_COUNT)) u_sec_tick (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .tick  (tick)
  );

  assign pps_next  = (accept && (pps_acc != 32'hFFFFFFFF)) ? pps_acc + 32'd1 : pps_acc;
  assign byte_sum  = {1'b0, byte_acc} + 33'(term_bytes);
  assign byte_next = !accept ? byte_acc : (byte_sum[32] ? 32'hFFFFFFFF : byte_sum[31:0]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pps_acc       <= 32'd0;
      byte_acc      <= 32'd0;
      rx_pps        <= 32'd0;
      rx_throughput <= 32'd0;
    end else if (tick) begin
      rx_pps        <= pps_next;
      rx_throughput <= byte_next;
      pps_acc       <= 32'd0;
      byte_acc      <= 32'd0;
    end else begin
      pps_acc  <= pps_next;
      byte_acc <= byte_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_measure.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rx_measure: randomized frame-level bench for rx_measure.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_rx_measure;

  localparam int unsigned SEC = 1000;
  localparam logic [39:0] MAGIC = 40'h01_23_45_67_89;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] xgmii_rxd = IDLE_D;
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic [31:0] global_counter = 32'd0;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;

  rx_measure #(.MAGIC_CODE(MAGIC), .SEC_COUNT(SEC)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .global_counter (global_counter),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_ipv4_ip     (rx_ipv4_ip)
  );

  always #3 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] gc = 32'd0;
  logic [31:0] acc_p = 32'd0;
  logic [31:0] acc_b = 32'd0;
  logic [31:0] exp_pps = 32'd0;
  logic [31:0] exp_thr = 32'd0;
  logic [23:0] exp_lat = 24'd0;
  logic [31:0] exp_ip = 32'd0;
  logic [7:0]  fb [0:2047];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] lat_rule(input logic [31:0] now, input logic [31:0] ts);
    longint diff;
    diff = longint'({32'd0, now}) - longint'({32'd0, ts});
    if (diff < 0) diff += 64'h1_0000_0000;
    return (diff < 64'h100_0000) ? diff[23:0] : 24'hFFFFFF;
  endfunction

  // One clock: drive, wait for the edge, then advance the frame-level model
  task automatic step(input logic [63:0] d, input logic [7:0] c, input bit acc,
                      input int nbytes, input logic [31:0] ts, input logic [31:0] ip);
    xgmii_rxd = d;
    xgmii_rxc = c;
    global_counter = gc;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (acc) begin
      acc_p   = acc_p + 32'd1;
      acc_b   = acc_b + 32'(nbytes);
      exp_ip  = ip;
      exp_lat = lat_rule(gc, ts);
    end
    gc = gc + 32'd1;
    if (cyc % SEC == 0) begin
      exp_pps = acc_p;
      exp_thr = acc_b;
      acc_p = 32'd0;
      acc_b = 32'd0;
      check("pps_tick", rx_pps, exp_pps);
      check("thr_tick", rx_throughput, exp_thr);
    end
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) step(IDLE_D, 8'hFF, 1'b0, 0, 32'd0, 32'd0);
  endtask

  // flaw: 0 none, 1 magic bit flip, 2 EtherType 86DD, 3 error char on word 4, 4 non-UDP
  // cut > 0: stop after words 0..cut-1 with no terminate
  task automatic send_frame(input logic [31:0] ts, input logic [31:0] ip, input int w_term,
                            input int lane, input int flaw, input int cut,
                            input logic [31:0] term_gc);
    int nb;
    bit valid;
    logic [63:0] d;
    logic [7:0]  c;
    nb = (w_term - 1) * 8 + lane;
    for (int i = 0; i < 64 || i < nb; i++) fb[i] = 8'($urandom);
    fb[12] = 8'h08; fb[13] = 8'h00; fb[23] = 8'h11;
    for (int i = 0; i < 4; i++) fb[30+i] = ip[31-8*i -: 8];
    for (int i = 0; i < 5; i++) fb[42+i] = MAGIC[39-8*i -: 8];
    for (int i = 0; i < 4; i++) fb[47+i] = ts[31-8*i -: 8];
    if (flaw == 1) fb[42 + $urandom_range(0, 4)] ^= 8'(1 << $urandom_range(0, 7));
    if (flaw == 2) begin fb[12] = 8'h86; fb[13] = 8'hDD; end
    if (flaw == 4) fb[23] = 8'h06;
    valid = (flaw == 0) && (w_term >= 8) && (cut == 0);

    step(64'hD5555555555555FB, 8'h01, 1'b0, 0, ts, ip);
    for (int w = 1; w < w_term; w++) begin
      if (cut > 0 && w == cut) return;
      c = 8'h00;
      for (int l = 0; l < 8; l++) d[8*l +: 8] = fb[(w-1)*8 + l];
      if (flaw == 3 && w == 4) begin d[31:24] = 8'hFE; c[3] = 1'b1; end
      step(d, c, 1'b0, 0, ts, ip);
    end
    c = 8'h00;
    for (int l = 0; l < 8; l++) begin
      if (l < lane) d[8*l +: 8] = fb[(w_term-1)*8 + l];
      else begin
        d[8*l +: 8] = (l == lane) ? 8'hFD : 8'h07;
        c[l] = 1'b1;
      end
    end
    gc = term_gc;
    step(d, c, valid, nb, ts, ip);
    check("latency", {8'd0, rx_latency}, {8'd0, exp_lat});
    check("ipv4", rx_ipv4_ip, exp_ip);
  endtask

  initial begin
    logic [31:0] ts, saved_ip;
    logic [23:0] saved_lat;

    // Reset held with random RX activity
    for (int i = 0; i < 20; i++) begin
      xgmii_rxd = {$urandom, $urandom};
      xgmii_rxc = 8'($urandom);
      global_counter = $urandom;
      @(posedge sys_clk);
      #1;
      if (i % 5 == 4) begin
        check("rst_pps", rx_pps, 32'd0);
        check("rst_thr", rx_throughput, 32'd0);
        check("rst_lat", {8'd0, rx_latency}, 32'd0);
        check("rst_ip", rx_ipv4_ip, 32'd0);
      end
    end
    xgmii_rxd = IDLE_D;
    xgmii_rxc = 8'hFF;
    sys_rst_n = 1'b1;
    cyc = 0;
    idle_until(10);
    check("rel_pps", rx_pps, 32'd0);
    check("rel_thr", rx_throughput, 32'd0);
    check("rel_lat", {8'd0, rx_latency}, 32'd0);
    check("rel_ip", rx_ipv4_ip, 32'd0);

    // Interval 1: reference frame plus nine more 60-byte frames
    send_frame(32'h00001000, 32'h0A000001, 8, 4, 0, 0, 32'h00001234);
    check("single_lat", {8'd0, rx_latency}, 32'h00000234);
    check("single_ip", rx_ipv4_ip, 32'h0A000001);
    for (int i = 0; i < 9; i++) begin
      ts = $urandom;
      send_frame(ts, $urandom, 8, 4, 0, 0, ts + $urandom_range(0, 5000));
      step(IDLE_D, 8'hFF, 1'b0, 0, 32'd0, 32'd0);
    end
    idle_until(SEC);
    check("pps_10", rx_pps, 32'd10);
    check("thr_600", rx_throughput, 32'd600);

    // Interval 2: silence
    idle_until(2 * SEC);
    check("pps_quiet", rx_pps, 32'd0);
    check("thr_quiet", rx_throughput, 32'd0);

    // Interval 3: rejections, restart, wrap/saturation, frame on the tick
    saved_lat = rx_latency;
    saved_ip  = rx_ipv4_ip;
    send_frame(32'h5, 32'hC0A80001, 8, 4, 1, 0, 32'h100);
    send_frame(32'h5, 32'hC0A80002, 8, 4, 2, 0, 32'h100);
    send_frame(32'h5, 32'hC0A80003, 5, 2, 0, 0, 32'h100);
    send_frame(32'h5, 32'hC0A80004, 8, 4, 3, 0, 32'h100);
    check("rej_lat", {8'd0, rx_latency}, {8'd0, saved_lat});
    check("rej_ip", rx_ipv4_ip, saved_ip);
    send_frame(32'h5, 32'hC0A800AA, 8, 4, 0, 3, 32'h100);
    send_frame(32'h20, 32'h0A000063, 8, 4, 0, 0, 32'h30);
    check("restart_ip", rx_ipv4_ip, 32'h0A000063);
    send_frame(32'hFFFFFFF0, 32'h0A000064, 8, 4, 0, 0, 32'h00000010);
    check("wrap_lat", {8'd0, rx_latency}, 32'h00000020);
    send_frame(32'h00000000, 32'h0A000065, 8, 4, 0, 0, 32'h01000000);
    check("sat_lat", {8'd0, rx_latency}, 32'h00FFFFFF);
    idle_until(3 * SEC - 9);
    send_frame(32'h77, 32'h0A000066, 8, 4, 0, 0, 32'h99);
    check("tick_cyc", cyc, 3 * SEC);
    check("pps_tickframe", rx_pps, 32'd4);
    check("thr_tickframe", rx_throughput, 32'd240);

    // Interval 4: random mix of lengths, lanes, flaws and gaps
    while (cyc < 4 * SEC - 60) begin
      int wt, fl;
      wt = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(8, 20);
      fl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      ts = $urandom;
      send_frame(ts, $urandom, wt, $urandom_range(0, 7), fl, 0,
                 ($urandom_range(0, 3) == 0) ? $urandom : ts + $urandom_range(0, 100000));
      repeat ($urandom_range(0, 2)) step(IDLE_D, 8'hFF, 1'b0, 0, 32'd0, 32'd0);
    end
    idle_until(4 * SEC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
